sprite_param_pio_bank: RTL and testbench



---
 rtl/sprite_pio_pkg.sv | 21 ++
 rtl/pio_sync_edge.sv | 31 +++
 rtl/sprite_param_pio_bank.sv | 144 ++++++++++++++
 tb/tb_sprite_param_pio_bank.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pio_pkg.sv
// Shared constants for the sprite parameter PIO bank: CTRL bit positions,
// frame counter width and register-map offsets.
package sprite_pio_pkg;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_IMM    = 1;
    localparam int CTRL_IRQEN  = 2;
    localparam int CTRL_IRQST  = 3;
    localparam int CTRL_AUTO   = 4;

    localparam int FRAME_CNT_W = 16;

    function automatic int ctrl_offset(input int num_ch);
        return num_ch;
    endfunction

    function automatic int frame_cnt_offset(input int num_ch);
        return num_ch + 1;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle pulse on each rising edge of the synchronised level.
module pio_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    // sync_q[1:0] is the synchroniser, sync_q[2] holds the previous level
    logic [2:0] sync_q, sync_d;
    logic       rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
        rise_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sprite_param_pio_bank.sv
// Avalon-MM bank of double-buffered sprite parameter channels. Shadow values
// move to out_port together on a vsync frame edge, or at once on IMM.
module sprite_param_pio_bank
    import sprite_pio_pkg::*;
#(
    parameter int                 NUM_CH    = 4,
    parameter int                 WIDTH     = 8,
    parameter int                 ADDR_W    = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic                      vsync_in,
    output logic [NUM_CH*WIDTH-1:0]   out_port,
    output logic                      irq
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(ctrl_offset(NUM_CH));
    localparam logic [ADDR_W-1:0] FRAME_ADDR = ADDR_W'(frame_cnt_offset(NUM_CH));

    logic [WIDTH-1:0]       shadow_q [NUM_CH];
    logic [WIDTH-1:0]       shadow_d [NUM_CH];
    logic [WIDTH-1:0]       active_q [NUM_CH];
    logic [WIDTH-1:0]       active_d [NUM_CH];
    logic                   pending_q, pending_d;
    logic                   irq_en_q, irq_en_d;
    logic                   irq_stat_q, irq_stat_d;
    logic                   auto_q, auto_d;
    logic                   fe_q, fe_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic rise;
    logic wr, wr_ctrl, commit_fe, copy;
    logic unused_wdata;

    pio_sync_edge u_vsync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vsync_in),
        .rise     (rise)
    );

    assign wr           = chipselect & ~write_n;
    assign wr_ctrl      = wr && (address == CTRL_ADDR);
    assign commit_fe    = fe_q & (pending_q | auto_q);
    assign copy         = commit_fe | (wr_ctrl & writedata[CTRL_IMM]);
    assign unused_wdata = ^writedata;

    // The extra fe stage places the copy on the fourth edge after vsync is first sampled
    always_comb begin
        // NOTE: every variable gets its default first so no latch can be inferred.
        fe_d        = rise;
        pending_d   = pending_q;
        irq_en_d    = irq_en_q;
        irq_stat_d  = irq_stat_q;
        auto_d      = auto_q;
        frame_cnt_d = frame_cnt_q;

        for (int k = 0; k < NUM_CH; k++) begin
            active_d[k] = copy ? shadow_q[k] : active_q[k];
            shadow_d[k] = (wr && (address == ADDR_W'(k))) ? writedata[WIDTH-1:0] : shadow_q[k];
        end

        if (fe_q) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
        if (commit_fe) begin
            pending_d = 1'b0;
        end

        // CPU writes are applied after the frame-edge consumption so a set always wins
        if (wr_ctrl) begin
            if (writedata[CTRL_COMMIT]) begin
                pending_d = 1'b1;
            end
            if (writedata[CTRL_IRQST]) begin
                irq_stat_d = 1'b0;
            end
            irq_en_d = writedata[CTRL_IRQEN];
            auto_d   = writedata[CTRL_AUTO];
        end
        if (copy) begin
            irq_stat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the channel banks are small flop arrays, so they are reset like any other state.
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= RESET_VAL;
                active_q[k] <= RESET_VAL;
            end
            pending_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_stat_q  <= 1'b0;
            auto_q      <= 1'b0;
            fe_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            pending_q   <= pending_d;
            irq_en_q    <= irq_en_d;
            irq_stat_q  <= irq_stat_d;
            auto_q      <= auto_d;
            fe_q        <= fe_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        readdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == ADDR_W'(k)) begin
                readdata = 32'(shadow_q[k]);
            end
        end
        if (address == CTRL_ADDR) begin
            readdata[CTRL_COMMIT] = pending_q;
            readdata[CTRL_IRQEN]  = irq_en_q;
            readdata[CTRL_IRQST]  = irq_stat_q;
            readdata[CTRL_AUTO]   = auto_q;
        end
        if (address == FRAME_ADDR) begin
            readdata = 32'(frame_cnt_q);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign out_port[k*WIDTH +: WIDTH] = active_q[k];
    end

    assign irq = irq_stat_q & irq_en_q;

endmodule

// File: tb/tb_sprite_param_pio_bank.sv
// Self-checking bench for sprite_param_pio_bank: register table, directed
// frame-edge corner cases, randomized traffic against a frame-level model.
module tb_sprite_param_pio_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [ADDR_W-1:0]       address = '0;
    logic                    chipselect = 1'b0;
    logic                    write_n = 1'b1;
    logic [31:0]             writedata = '0;
    logic [31:0]             readdata;
    logic                    vsync_in = 1'b0;
    logic [NUM_CH*WIDTH-1:0] out_port;
    logic                    irq;

    always #5 clk = ~clk;

    sprite_param_pio_bank #(
        .NUM_CH    (NUM_CH),
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W),
        .RESET_VAL ('0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .vsync_in   (vsync_in),
        .out_port   (out_port),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file of the CPU view plus a list of pending
    // frame edges, each due four clock edges after vsync is sampled rising.
    logic [WIDTH-1:0] m_shadow [NUM_CH];
    logic [WIDTH-1:0] m_active [NUM_CH];
    logic             m_pending, m_irq_en, m_irq_stat, m_auto, m_last_vs;
    int               m_frame;
    int               fe_due[$];

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_pending = 0; m_irq_en = 0; m_irq_stat = 0; m_auto = 0; m_last_vs = 0;
        m_frame = 0;
        fe_due.delete();
    endtask

    task automatic model_edge(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic vs);
        logic fe, frame_copy, imm_copy;
        fe = 0;
        for (int i = 0; i < fe_due.size(); i++) fe_due[i] = fe_due[i] - 1;
        while (fe_due.size() > 0 && fe_due[0] == 0) begin
            fe = 1;
            void'(fe_due.pop_front());
        end
        if (vs && !m_last_vs) fe_due.push_back(4);
        m_last_vs = vs;

        frame_copy = fe && (m_pending || m_auto);
        imm_copy   = wr && (a == 4'(NUM_CH)) && d[1];
        if (frame_copy || imm_copy) begin
            for (int k = 0; k < NUM_CH; k++) m_active[k] = m_shadow[k];
        end
        if (fe) m_frame = (m_frame + 1) % 65536;
        if (frame_copy) m_pending = 0;
        if (wr) begin
            if (a < 4'(NUM_CH)) m_shadow[a] = d[WIDTH-1:0];
            else if (a == 4'(NUM_CH)) begin
                if (d[0]) m_pending = 1;
                if (d[3]) m_irq_stat = 0;
                m_irq_en = d[2];
                m_auto   = d[4];
            end
        end
        if (frame_copy || imm_copy) m_irq_stat = 1;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a < 4'(NUM_CH)) return 32'(m_shadow[a]);
        if (a == 4'(NUM_CH)) return {27'd0, m_auto, m_irq_stat, m_irq_en, 1'b0, m_pending};
        if (a == 4'(NUM_CH + 1)) return 32'(m_frame);
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_out();
        logic [31:0] o;
        o = '0;
        for (int k = 0; k < NUM_CH; k++) o[k*WIDTH +: WIDTH] = m_active[k];
        return o;
    endfunction

    logic [31:0] rd_last;

    // One bus cycle: drive, check readdata, clock, update model, check outputs.
    task automatic step(input logic cs, input logic wn, input logic [3:0] a,
                        input logic [31:0] d, input logic vs);
        chipselect = cs; write_n = wn; address = a; writedata = d; vsync_in = vs;
        #1;
        rd_last = readdata;
        check("readdata", readdata, model_read(a));
        @(posedge clk);
        model_edge(cs & ~wn, a, d, vs);
        #1;
        check("out_port", out_port, model_out());
        check("irq", 32'(irq), 32'(m_irq_stat & m_irq_en));
    endtask

    task automatic idle(input logic vs);
        step(1'b0, 1'b1, 4'd0, 32'd0, vs);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic vs);
        step(1'b1, 1'b0, a, d, vs);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b1, a, 32'd0, 1'b0);
    endtask

    task automatic pulse_vsync();
        repeat (3) idle(1'b1);
        repeat (6) idle(1'b0);
    endtask

    task automatic do_reset();
        chipselect = 0; write_n = 1; address = '0; writedata = '0; vsync_in = 0;
        reset_n = 1'b0;
        #2;
        check("rst_out_port", out_port, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[13];
    logic vs_r;

    initial begin
        vecs[0]  = '{4'h0, 32'h0000_01FF, 32'h0000_00FF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{4'h3, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_0000, 1'b0};
        vecs[2]  = '{4'h4, 32'h0000_0014, 32'h0000_0014, 32'h0000_0000, 1'b0};
        vecs[3]  = '{4'h4, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4]  = '{4'h5, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5]  = '{4'hF, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{4'h4, 32'h0000_0002, 32'h0000_0008, 32'hA500_00FF, 1'b0};
        vecs[7]  = '{4'h4, 32'h0000_0008, 32'h0000_0000, 32'hA500_00FF, 1'b0};
        vecs[8]  = '{4'h4, 32'h0000_0001, 32'h0000_0001, 32'hA500_00FF, 1'b0};
        vecs[9]  = '{4'h4, 32'h0000_0000, 32'h0000_0001, 32'hA500_00FF, 1'b0};
        vecs[10] = '{4'h1, 32'h0000_0011, 32'h0000_0011, 32'hA500_00FF, 1'b0};
        vecs[11] = '{4'h4, 32'h0000_000E, 32'h0000_000D, 32'hA500_11FF, 1'b1};
        vecs[12] = '{4'h4, 32'h0000_0008, 32'h0000_0001, 32'hA500_11FF, 1'b0};

        do_reset();
        for (int a = 0; a < NUM_CH + 2; a++) begin
            rd(4'(a));
            check("reset_read", rd_last, 32'd0);
        end

        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].wd, 1'b0);
            rd(vecs[i].addr);
            check($sformatf("vec%0d_rd", i), rd_last, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), out_port, vecs[i].exp_out);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Reset while pending is set; nothing may commit afterwards without a new COMMIT.
        do_reset();
        check("midrst_out", out_port, 32'd0);
        for (int a = 0; a < NUM_CH + 2; a++) begin
            rd(4'(a));
            check("midrst_read", rd_last, 32'd0);
        end

        wr(4'h2, 32'h5A, 1'b0);
        for (int p = 0; p < 3; p++) begin
            pulse_vsync();
            check("iso_ch2", 32'(out_port[23:16]), 32'h00);
        end
        wr(4'h4, 32'h1, 1'b0);
        idle(1'b1);
        check("lat_e0", 32'(out_port[23:16]), 32'h00);
        idle(1'b1);
        check("lat_e1", 32'(out_port[23:16]), 32'h00);
        idle(1'b1);
        check("lat_e2", 32'(out_port[23:16]), 32'h00);
        idle(1'b0);
        check("lat_e3", 32'(out_port[23:16]), 32'h00);
        idle(1'b0);
        check("lat_e4", 32'(out_port[23:16]), 32'h5A);
        repeat (4) idle(1'b0);
        rd(4'h4);
        check("commit_cleared", 32'(rd_last[0]), 32'd0);
        rd(4'h5);
        check("frame_cnt4", rd_last, 32'd4);

        wr(4'h4, 32'h4, 1'b0);
        wr(4'h0, 32'h81, 1'b0);
        wr(4'h4, 32'h6, 1'b0);
        check("imm_ch0", 32'(out_port[7:0]), 32'h81);
        check("imm_irq", 32'(irq), 32'd1);
        wr(4'h4, 32'hC, 1'b0);
        check("irq_clear", 32'(irq), 32'd0);

        // Shadow write on the commit edge: the old value is copied.
        wr(4'h1, 32'h11, 1'b0);
        wr(4'h4, 32'h1, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b0);
        wr(4'h1, 32'h33, 1'b0);
        check("coll_old_active", 32'(out_port[15:8]), 32'h11);
        rd(4'h1);
        check("coll_new_shadow", rd_last, 32'h33);

        // COMMIT written on the commit edge survives it.
        wr(4'h4, 32'h1, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b0);
        wr(4'h4, 32'h1, 1'b0);
        check("coll2_active", 32'(out_port[15:8]), 32'h33);
        rd(4'h4);
        check("coll2_pending", 32'(rd_last[0]), 32'd1);
        wr(4'h1, 32'h44, 1'b0);
        pulse_vsync();
        check("coll2_next", 32'(out_port[15:8]), 32'h44);
        rd(4'h4);
        check("coll2_consumed", 32'(rd_last[0]), 32'd0);

        wr(4'h4, 32'h10, 1'b0);
        begin
            logic [7:0] vals [3];
            vals = '{8'h3C, 8'hC3, 8'h7E};
            for (int f = 0; f < 3; f++) begin
                wr(4'h3, 32'(vals[f]), 1'b0);
                check("auto_hold", 32'(out_port[31:24]), f == 0 ? 32'h00 : 32'(vals[f-1]));
                pulse_vsync();
                check("auto_track", 32'(out_port[31:24]), 32'(vals[f]));
            end
        end
        wr(4'h4, 32'h0, 1'b0);

        do_reset();
        vs_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 5) == 0) vs_r = ~vs_r;
            a = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NUM_CH + 1));
            d = $urandom;
            if (a == 4'(NUM_CH) && $urandom_range(0, 2) != 0) d[1] = 1'b0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, vs_r);
        end

        do_reset();
        for (int p = 0; p < 65536; p++) begin
            idle(1'b1);
            idle(1'b0);
        end
        repeat (6) idle(1'b0);
        rd(4'h5);
        check("frame_wrap", rd_last, 32'd0);
        wr(4'hF, 32'hFFFF_FFFF, 1'b0);
        rd(4'hF);
        check("unmapped_read", rd_last, 32'd0);
        for (int a = 0; a < NUM_CH + 2; a++) begin
            rd(4'(a));
            check("unmapped_nochange", rd_last, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
